cond_logic: RTL

//  Consumer end of the ALU flag interface: holds the architectural NZCV register,
//  fed by alu ALUFlags {N,Z,C,V}. Evaluates the 4-bit ARM condition field of the

---
 rtl/cond_logic.sv | 107 ++++++++++
 1 files changed

// File: rtl/cond_logic.sv
// ARM condition-code unit: holds the architectural NZCV flags, evaluates the
// instruction condition field against them, gates write enables and counts skips.
module cond_logic #(
  parameter int REG_OUT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_w,
  input  logic             pcs,
  input  logic             reg_w,
  input  logic             mem_w,
  input  logic             no_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_write,
  output logic             cond_ex,
  output logic [3:0]       flags_o,
  output logic [CNT_W-1:0] skip_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] skip_q, skip_d;
  logic             flag_n, flag_z, flag_c, flag_v;
  logic             pass;
  logic             ex_c;
  // Packed as {cond_ex, pc_src, reg_write, mem_write}.
  logic [3:0]       en_d;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // Evaluation always uses the stored flags, so an instruction that updates the
  // flags sees the values from before its own update.
  always_comb begin
    pass = 1'b1;
    case (cond)
      4'b0000: pass = flag_z;
      4'b0001: pass = ~flag_z;
      4'b0010: pass = flag_c;
      4'b0011: pass = ~flag_c;
      4'b0100: pass = flag_n;
      4'b0101: pass = ~flag_n;
      4'b0110: pass = flag_v;
      4'b0111: pass = ~flag_v;
      4'b1000: pass = flag_c & ~flag_z;
      4'b1001: pass = ~flag_c | flag_z;
      4'b1010: pass = (flag_n == flag_v);
      4'b1011: pass = (flag_n != flag_v);
      4'b1100: pass = ~flag_z & (flag_n == flag_v);
      4'b1101: pass = flag_z | (flag_n != flag_v);
      default: pass = 1'b1;
    endcase
  end

  always_comb begin
    ex_c = valid_i & pass;
    en_d = {ex_c, ex_c & pcs, ex_c & reg_w & ~no_write, ex_c & mem_w};
  end

  always_comb begin
    flags_d = flags_q;
    if (ex_c) begin
      if (flag_w[1]) flags_d[3:2] = alu_flags[3:2];
      if (flag_w[0]) flags_d[1:0] = alu_flags[1:0];
    end
  end

  always_comb begin
    skip_d = skip_q;
    if (valid_i && !pass && (skip_q != {CNT_W{1'b1}})) skip_d = skip_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
      skip_q  <= '0;
    end else begin
      flags_q <= flags_d;
      skip_q  <= skip_d;
    end
  end

  assign flags_o    = flags_q;
  assign skip_count = skip_q;

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [3:0] en_q;
      always_ff @(posedge clk) begin
        if (reset) en_q <= 4'b0000;
        else       en_q <= en_d;
      end
      assign {cond_ex, pc_src, reg_write, mem_write} = en_q;
    end else begin : g_comb_out
      assign {cond_ex, pc_src, reg_write, mem_write} = en_d;
    end
  endgenerate

endmodule
